// File: rtl/primitive_calculator_if.sv
// Primitive calculator user I/O bundle: buttons, encoder phases and display outputs.
// master drives the user inputs (board / bench); slave is the calculator core.
interface primitive_calculator_if;
    logic       select;
    logic       restart;
    logic       rotary_a;
    logic       rotary_b;
    logic [6:0] seven_segment_out;
    logic       seven_segment_digit;
    logic       led_flag;
    logic       sync;

    modport master (
        output select, restart, rotary_a, rotary_b,
        input  seven_segment_out, seven_segment_digit, led_flag, sync
    );

    modport slave (
        input  select, restart, rotary_a, rotary_b,
        output seven_segment_out, seven_segment_digit, led_flag, sync
    );
endinterface

// File: rtl/primitive_calculator.sv
// Primitive calculator: enter A, pick op (add/sub/mul), enter B, show result on a
// two-digit multiplexed seven-segment display.
// Optional macro PRIMCALC_DEBOUNCE_EN adds a 4-sample filter after the synchronizers.
module primitive_calculator #(
    parameter int unsigned MUX_BITS = 10
) (
    input logic                   clk,
    input logic                   reset,
    primitive_calculator_if.slave cal
);
    typedef enum logic [1:0] {StA, StOp, StB, StRes} state_t;

    // Bit order: 0 select, 1 restart, 2 rotary_a, 3 rotary_b
    logic [3:0] raw;
    logic [3:0] meta_q, sync_q, level;
    logic [2:0] prev_q;
    logic       select_edge, restart_edge, rot_edge, rot_ccw;

    state_t        state_q, state_d;
    logic [3:0]    a_q, a_d, b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [6:0]    res_q, res_d, calc_mag;
    logic          neg_q, neg_d, calc_neg;
    logic [6:0]    a_ext, b_ext, disp_val, tens_val, units_val;
    logic [6:0]    tens_code, units_code;
    logic [MUX_BITS-1:0] cnt_q;
    logic          digit_q, digit_d;
    logic [6:0]    seg_q;
    logic          led_q, pulse_q, in_res_q;

    assign raw = {cal.rotary_b, cal.rotary_a, cal.restart, cal.select};

    function automatic logic [6:0] seg(input logic [6:0] v);
        case (v)
            7'd0:    seg = 7'h3F;
            7'd1:    seg = 7'h06;
            7'd2:    seg = 7'h5B;
            7'd3:    seg = 7'h4F;
            7'd4:    seg = 7'h66;
            7'd5:    seg = 7'h6D;
            7'd6:    seg = 7'h7D;
            7'd7:    seg = 7'h07;
            7'd8:    seg = 7'h7F;
            7'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    endfunction

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

`ifdef PRIMCALC_DEBOUNCE_EN
    logic [3:0] filt_q;
    logic [1:0] dcnt_q [4];

    // Filtered level follows only after 4 consecutive samples differing from it
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == 2'd3) begin
                    filt_q[i] <= sync_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 2'd1;
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q;
`endif

    // Previous levels for rising-edge detection (rotary_b is used as a level only)
    always_ff @(posedge clk) begin
        if (reset) prev_q <= '0;
        else       prev_q <= level[2:0];
    end

    assign select_edge  = level[0] & ~prev_q[0];
    assign restart_edge = level[1] & ~prev_q[1];
    assign rot_edge     = level[2] & ~prev_q[2];
    assign rot_ccw      = level[3];
    assign a_ext        = {3'b000, a_q};
    assign b_ext        = {3'b000, b_q};

    // Arithmetic on the current operands; latched only when leaving S_B
    always_comb begin
        calc_mag = '0;
        calc_neg = 1'b0;
        case (op_q)
            2'd0: calc_mag = a_ext + b_ext;
            2'd1: begin
                calc_neg = (a_q < b_q);
                calc_mag = calc_neg ? (b_ext - a_ext) : (a_ext - b_ext);
            end
            2'd2: calc_mag = a_ext * b_ext;
            default: calc_mag = '0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
        end
    end

    // Next state: restart beats select, select beats a rotary step
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        neg_d   = neg_q;
        if (restart_edge) begin
            state_d = StA;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (select_edge) begin
            unique case (state_q)
                StA:  state_d = StOp;
                StOp: state_d = StB;
                StB: begin
                    state_d = StRes;
                    res_d   = calc_mag;
                    neg_d   = calc_neg;
                end
                StRes: begin
                    state_d = StA;
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = '0;
                end
            endcase
        end else if (rot_edge) begin
            unique case (state_q)
                StA:  a_d  = rot_ccw ? ((a_q == 4'd0) ? 4'd9 : a_q - 4'd1)
                                     : ((a_q == 4'd9) ? 4'd0 : a_q + 4'd1);
                StOp: op_d = rot_ccw ? ((op_q == 2'd0) ? 2'd2 : op_q - 2'd1)
                                     : ((op_q == 2'd2) ? 2'd0 : op_q + 2'd1);
                StB:  b_d  = rot_ccw ? ((b_q == 4'd0) ? 4'd9 : b_q - 4'd1)
                                     : ((b_q == 4'd9) ? 4'd0 : b_q + 4'd1);
                StRes: ;
            endcase
        end
    end

    // Value on display and its decimal digit codes
    always_comb begin
        disp_val = '0;
        unique case (state_q)
            StA:   disp_val = a_ext;
            StOp:  disp_val = {5'b00000, op_q};
            StB:   disp_val = b_ext;
            StRes: disp_val = res_q;
        endcase
        tens_val   = disp_val / 7'd10;
        units_val  = disp_val % 7'd10;
        units_code = seg(units_val);
        tens_code  = (disp_val < 7'd10) ? 7'h00 : seg(tens_val);
        digit_d    = (&cnt_q) ? ~digit_q : digit_q;
    end

    // Output registers; segment data is chosen with the digit select it is shown with
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            digit_q  <= 1'b0;
            seg_q    <= 7'h3F;
            led_q    <= 1'b0;
            pulse_q  <= 1'b0;
            in_res_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + MUX_BITS'(1);
            digit_q  <= digit_d;
            seg_q    <= digit_d ? tens_code : units_code;
            led_q    <= (state_q == StRes) & neg_q;
            in_res_q <= (state_q == StRes);
            pulse_q  <= (state_q == StRes) & ~in_res_q;
        end
    end

    assign cal.seven_segment_out   = seg_q;
    assign cal.seven_segment_digit = digit_q;
    assign cal.led_flag            = led_q;
    assign cal.sync                = pulse_q;
endmodule

// File: tb/tb_primitive_calculator.sv
// Directed bench for primitive_calculator with MUX_BITS=2.
// Timing is chosen to also cover builds with PRIMCALC_DEBOUNCE_EN defined.
module tb_primitive_calculator;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sync_total = 0;
    int   sync_snap;
    logic [7:0] units, tens;

    primitive_calculator_if cal ();

    primitive_calculator #(.MUX_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .cal   (cal)
    );

    always #5 clk = ~clk;

    // Count sync pulses seen (sampled on the falling edge)
    always @(negedge clk) begin
        if (cal.sync === 1'b1) sync_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic press_select();
        cal.select = 1'b1; tick(10);
        cal.select = 1'b0; tick(10);
    endtask

    task automatic press_restart();
        cal.restart = 1'b1; tick(10);
        cal.restart = 1'b0; tick(10);
    endtask

    // One encoder detent: phase B level sets direction, A rising edge clocks it
    task automatic step(input logic ccw, input int n);
        for (int i = 0; i < n; i++) begin
            cal.rotary_b = ccw; tick(2);
            cal.rotary_a = 1'b1; tick(10);
            cal.rotary_a = 1'b0; tick(10);
            cal.rotary_b = 1'b0; tick(2);
        end
    endtask

    // Capture both multiplexed digits over several mux periods
    task automatic read_digits(output logic [7:0] u, output logic [7:0] t);
        logic got_u, got_t;
        got_u = 1'b0; got_t = 1'b0; u = 8'hFF; t = 8'hFF;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            if (cal.seven_segment_digit === 1'b0 && !got_u) begin
                u = {1'b0, cal.seven_segment_out}; got_u = 1'b1;
            end else if (cal.seven_segment_digit === 1'b1 && !got_t) begin
                t = {1'b0, cal.seven_segment_out}; got_t = 1'b1;
            end
        end
        check("digit_scan", {6'b0, got_u, got_t}, 8'h03);
    endtask

    initial begin
        logic d0, d1, found;
        reset = 1'b1;
        cal.select = 1'b0; cal.restart = 1'b0; cal.rotary_a = 1'b0; cal.rotary_b = 1'b0;
        tick(3);
        check("rst_seg",   {1'b0, cal.seven_segment_out}, 8'h3F);
        check("rst_digit", {7'b0, cal.seven_segment_digit}, 8'h00);
        check("rst_led",   {7'b0, cal.led_flag}, 8'h00);
        check("rst_sync",  {7'b0, cal.sync}, 8'h00);
        reset = 1'b0;

        // Digit select toggles every 4 cycles
        d0 = cal.seven_segment_digit; found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (cal.seven_segment_digit !== d0) begin found = 1'b1; break; end
        end
        check("toggle_found", {7'b0, found}, 8'h01);
        d1 = cal.seven_segment_digit;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("digit_hold", {7'b0, cal.seven_segment_digit}, {7'b0, d1});
        end
        tick(1);
        check("digit_toggle", {7'b0, cal.seven_segment_digit}, {7'b0, ~d1});
        read_digits(units, tens);
        check("rst_units", units, 8'h3F);
        check("rst_tens",  tens,  8'h00);

        // 3 + 5 = 8
        step(1'b0, 3); press_select(); press_select();
        step(1'b0, 5);
        sync_snap = sync_total;
        press_select();
        check("add_sync_count", 8'(sync_total - sync_snap), 8'd1);
        read_digits(units, tens);
        check("add_units", units, 8'h7F);
        check("add_tens",  tens,  8'h00);
        check("add_led",   {7'b0, cal.led_flag}, 8'h00);

        // 2 - 7 = -5
        press_restart();
        step(1'b0, 2); press_select();
        step(1'b0, 1); press_select();
        step(1'b0, 7); press_select();
        read_digits(units, tens);
        check("sub_units", units, 8'h6D);
        check("sub_tens",  tens,  8'h00);
        check("sub_led",   {7'b0, cal.led_flag}, 8'h01);

        // Reset mid-operation discards the negative result
        reset = 1'b1; tick(2);
        check("midrst_seg", {1'b0, cal.seven_segment_out}, 8'h3F);
        reset = 1'b0; tick(4);
        check("midrst_led", {7'b0, cal.led_flag}, 8'h00);
        read_digits(units, tens);
        check("midrst_units", units, 8'h3F);

        // Wrap checks, then 9 * 9 = 81
        step(1'b1, 1);
        read_digits(units, tens);
        check("a_wrap_down", units, 8'h6F);
        step(1'b0, 1);
        read_digits(units, tens);
        check("a_wrap_up", units, 8'h3F);
        step(1'b1, 1); press_select();
        step(1'b0, 2);
        read_digits(units, tens);
        check("op_mul", units, 8'h5B);
        step(1'b0, 1);
        read_digits(units, tens);
        check("op_wrap", units, 8'h3F);
        step(1'b0, 2); press_select();
        step(1'b1, 1);
        sync_snap = sync_total;
        press_select();
        check("mul_sync_count", 8'(sync_total - sync_snap), 8'd1);
        read_digits(units, tens);
        check("mul_units", units, 8'h06);
        check("mul_tens",  tens,  8'h7F);
        check("mul_led",   {7'b0, cal.led_flag}, 8'h00);

        // Restart and select together while in S_B with b=4
        press_restart();
        press_select(); press_select();
        step(1'b0, 4);
        read_digits(units, tens);
        check("b_is_4", units, 8'h66);
        sync_snap = sync_total;
        cal.restart = 1'b1; cal.select = 1'b1; tick(10);
        cal.restart = 1'b0; cal.select = 1'b0; tick(10);
        check("both_sync_count", 8'(sync_total - sync_snap), 8'd0);
        read_digits(units, tens);
        check("both_units", units, 8'h3F);
        step(1'b0, 4);
        read_digits(units, tens);
        check("both_in_a", units, 8'h66);

`ifdef PRIMCALC_DEBOUNCE_EN
        // Short glitch is filtered; a full press advances exactly once
        press_restart();
        step(1'b0, 3);
        cal.select = 1'b1; tick(2);
        cal.select = 1'b0; tick(20);
        read_digits(units, tens);
        check("glitch_ignored", units, 8'h4F);
        press_select();
        step(1'b0, 4);
        read_digits(units, tens);
        check("single_advance", units, 8'h06);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
